// File: rtl/riscv_pkg.sv
// Shared types and constants for the memory arbiter.
package riscv_pkg;

  localparam int XLEN           = 32;
  localparam int ARB_STARVE_MAX = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_IF = 2'd1,
    WAIT_LS = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store,
// with starvation protection for fetch and flush-kill of in-flight fetches.
module mem_arbiter
  import riscv_pkg::*;
#(
  parameter int STARVE_MAX = ARB_STARVE_MAX
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            if_req_v_i,
  input  logic [XLEN-1:0] if_adr_i,
  output logic            if_gnt_o,
  output logic            if_rsp_v_o,
  output logic [31:0]     if_rsp_data_o,
  input  logic            ls_req_v_i,
  input  logic [XLEN-1:0] ls_adr_i,
  input  logic            ls_we_i,
  input  logic [3:0]      ls_be_i,
  input  logic [31:0]     ls_wdata_i,
  output logic            ls_gnt_o,
  output logic            ls_rsp_v_o,
  output logic [31:0]     ls_rsp_data_o,
  input  logic            flush_v_i,
  output logic            mem_req_v_o,
  output logic [XLEN-1:0] mem_adr_o,
  output logic            mem_we_o,
  output logic [3:0]      mem_be_o,
  output logic [31:0]     mem_wdata_o,
  input  logic            mem_rdy_i,
  input  logic            mem_rsp_v_i,
  input  logic [31:0]     mem_rdata_i
);

  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  arb_state_t state_q;
  logic       drop_q;
  logic [2:0] starve_q;

  logic issue_s;
  logic sel_if_s;
  logic sel_ls_s;

  // Requester selection; gated by reset so every output reads 0 while held in reset.
  always_comb begin
    issue_s  = 1'b0;
    sel_if_s = 1'b0;
    sel_ls_s = 1'b0;
    if (reset_n && (state_q == IDLE)) begin
      issue_s  = if_req_v_i | ls_req_v_i;
      sel_if_s = if_req_v_i & (~ls_req_v_i | (starve_q == STARVE_LIM));
      sel_ls_s = ls_req_v_i & ~sel_if_s;
    end else begin
      issue_s  = 1'b0;
      sel_if_s = 1'b0;
      sel_ls_s = 1'b0;
    end
  end

  // Request payload muxing; a fetch always reads a full word.
  always_comb begin
    mem_adr_o   = {XLEN{1'b0}};
    mem_we_o    = 1'b0;
    mem_be_o    = 4'b0000;
    mem_wdata_o = 32'h0000_0000;
    if (sel_if_s) begin
      mem_adr_o = if_adr_i;
      mem_be_o  = 4'b1111;
    end else if (sel_ls_s) begin
      mem_adr_o   = ls_adr_i;
      mem_we_o    = ls_we_i;
      mem_be_o    = ls_be_i;
      mem_wdata_o = ls_wdata_i;
    end else begin
      mem_adr_o = {XLEN{1'b0}};
    end
  end

  assign mem_req_v_o   = issue_s;
  assign if_gnt_o      = sel_if_s & mem_rdy_i;
  assign ls_gnt_o      = sel_ls_s & mem_rdy_i;
  assign if_rsp_v_o    = (state_q == WAIT_IF) & mem_rsp_v_i & ~drop_q & ~flush_v_i;
  assign ls_rsp_v_o    = (state_q == WAIT_LS) & mem_rsp_v_i;
  assign if_rsp_data_o = reset_n ? mem_rdata_i : 32'h0000_0000;
  assign ls_rsp_data_o = reset_n ? mem_rdata_i : 32'h0000_0000;

  // Transaction FSM, fetch-kill flag and fetch starvation counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      drop_q   <= 1'b0;
      starve_q <= 3'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (if_gnt_o) begin
            state_q  <= WAIT_IF;
            drop_q   <= flush_v_i;
            starve_q <= 3'd0;
          end else if (ls_gnt_o) begin
            state_q  <= WAIT_LS;
            drop_q   <= 1'b0;
            if (!if_req_v_i) begin
              starve_q <= 3'd0;
            end else if (starve_q != STARVE_LIM) begin
              starve_q <= starve_q + 3'd1;
            end else begin
              starve_q <= starve_q;
            end
          end else begin
            state_q <= IDLE;
            drop_q  <= 1'b0;
            if (!if_req_v_i) begin
              starve_q <= 3'd0;
            end else begin
              starve_q <= starve_q;
            end
          end
        end
        WAIT_IF: begin
          if (mem_rsp_v_i) begin
            state_q <= IDLE;
            drop_q  <= 1'b0;
          end else if (flush_v_i) begin
            drop_q <= 1'b1;
          end else begin
            drop_q <= drop_q;
          end
        end
        WAIT_LS: begin
          if (mem_rsp_v_i) begin
            state_q <= IDLE;
            drop_q  <= 1'b0;
          end else begin
            state_q <= WAIT_LS;
          end
        end
        default: begin
          state_q  <= IDLE;
          drop_q   <= 1'b0;
          starve_q <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scenarios plus a randomized run against a transaction-level model.
module tb_mem_arbiter;
  import riscv_pkg::*;

  localparam int SMAX = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        if_req_v_i, ls_req_v_i, ls_we_i, flush_v_i;
  logic [31:0] if_adr_i, ls_adr_i, ls_wdata_i, mem_rdata_i;
  logic [3:0]  ls_be_i;
  logic        mem_rdy_i, mem_rsp_v_i;
  logic        if_gnt_o, if_rsp_v_o, ls_gnt_o, ls_rsp_v_o;
  logic [31:0] if_rsp_data_o, ls_rsp_data_o, mem_adr_o, mem_wdata_o;
  logic        mem_req_v_o, mem_we_o;
  logic [3:0]  mem_be_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req_v_i(if_req_v_i), .if_adr_i(if_adr_i), .if_gnt_o(if_gnt_o),
    .if_rsp_v_o(if_rsp_v_o), .if_rsp_data_o(if_rsp_data_o),
    .ls_req_v_i(ls_req_v_i), .ls_adr_i(ls_adr_i), .ls_we_i(ls_we_i), .ls_be_i(ls_be_i),
    .ls_wdata_i(ls_wdata_i), .ls_gnt_o(ls_gnt_o), .ls_rsp_v_o(ls_rsp_v_o),
    .ls_rsp_data_o(ls_rsp_data_o), .flush_v_i(flush_v_i),
    .mem_req_v_o(mem_req_v_o), .mem_adr_o(mem_adr_o), .mem_we_o(mem_we_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_rdy_i(mem_rdy_i),
    .mem_rsp_v_i(mem_rsp_v_i), .mem_rdata_i(mem_rdata_i)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    if_req_v_i = 1'b0; ls_req_v_i = 1'b0; ls_we_i = 1'b0; flush_v_i = 1'b0;
    if_adr_i = 32'h0; ls_adr_i = 32'h0; ls_wdata_i = 32'h0; ls_be_i = 4'h0;
    mem_rdy_i = 1'b1; mem_rsp_v_i = 1'b0; mem_rdata_i = 32'h0;
  endtask

  task automatic test_reset;
    if_req_v_i = 1'b1; if_adr_i = 32'h0000_0AA0;
    ls_req_v_i = 1'b1; ls_adr_i = 32'h0000_0BB0; ls_we_i = 1'b1; ls_be_i = 4'hF;
    ls_wdata_i = 32'h1234_5678; mem_rsp_v_i = 1'b1; mem_rdata_i = 32'hCAFE_F00D;
    @(negedge clk);
    checks++; if (mem_req_v_o !== 1'b0) begin errors++; $display("FAIL rst_req got %0h want 0", mem_req_v_o); end
    checks++; if (mem_adr_o !== 32'h0) begin errors++; $display("FAIL rst_adr got %0h want 0", mem_adr_o); end
    checks++; if (mem_wdata_o !== 32'h0) begin errors++; $display("FAIL rst_wdata got %0h want 0", mem_wdata_o); end
    checks++; if ({if_gnt_o, ls_gnt_o, if_rsp_v_o, ls_rsp_v_o, mem_we_o} !== 5'b0) begin errors++; $display("FAIL rst_ctl got %b want 00000", {if_gnt_o, ls_gnt_o, if_rsp_v_o, ls_rsp_v_o, mem_we_o}); end
    checks++; if ({if_rsp_data_o, ls_rsp_data_o} !== 64'h0) begin errors++; $display("FAIL rst_rdata got %0h want 0", {if_rsp_data_o, ls_rsp_data_o}); end
    checks++; if (dut.state_q !== IDLE || dut.drop_q !== 1'b0 || dut.starve_q !== 3'd0) begin errors++; $display("FAIL rst_state got %0d/%0d/%0d want 0/0/0", dut.state_q, dut.drop_q, dut.starve_q); end
    tick;
    reset_n = 1'b1; mem_rsp_v_i = 1'b0;
    @(negedge clk);
    checks++; if (ls_gnt_o !== 1'b1 || if_gnt_o !== 1'b0) begin errors++; $display("FAIL first_cycle_gnt got ls=%0b if=%0b want ls=1 if=0", ls_gnt_o, if_gnt_o); end
    tick; idle_inputs;
    tick; mem_rsp_v_i = 1'b1;
    tick; mem_rsp_v_i = 1'b0;
  endtask

  task automatic test_if_only;
    if_req_v_i = 1'b1; if_adr_i = 32'h0000_0100;
    @(negedge clk);
    checks++; if (mem_req_v_o !== 1'b1 || mem_adr_o !== 32'h100) begin errors++; $display("FAIL if_issue got req=%0b adr=%0h want 1/100", mem_req_v_o, mem_adr_o); end
    checks++; if (if_gnt_o !== 1'b1 || ls_gnt_o !== 1'b0) begin errors++; $display("FAIL if_gnt got %0b/%0b want 1/0", if_gnt_o, ls_gnt_o); end
    tick; if_req_v_i = 1'b0;
    @(negedge clk);
    checks++; if (if_gnt_o !== 1'b0 || mem_req_v_o !== 1'b0) begin errors++; $display("FAIL if_wait got gnt=%0b req=%0b want 0/0", if_gnt_o, mem_req_v_o); end
    tick; tick;
    mem_rsp_v_i = 1'b1; mem_rdata_i = 32'h0000_0013;
    @(negedge clk);
    checks++; if (if_rsp_v_o !== 1'b1 || if_rsp_data_o !== 32'h13) begin errors++; $display("FAIL if_rsp got v=%0b d=%0h want 1/13", if_rsp_v_o, if_rsp_data_o); end
    tick; mem_rsp_v_i = 1'b0;
    @(negedge clk);
    checks++; if (dut.state_q !== IDLE || if_rsp_v_o !== 1'b0) begin errors++; $display("FAIL if_done got st=%0d v=%0b want 0/0", dut.state_q, if_rsp_v_o); end
  endtask

  task automatic test_both_store;
    if_req_v_i = 1'b1; if_adr_i = 32'h0000_0200;
    ls_req_v_i = 1'b1; ls_adr_i = 32'h0000_2000; ls_we_i = 1'b1; ls_be_i = 4'hF; ls_wdata_i = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++; if (ls_gnt_o !== 1'b1 || if_gnt_o !== 1'b0) begin errors++; $display("FAIL both_ls_first got ls=%0b if=%0b want 1/0", ls_gnt_o, if_gnt_o); end
    checks++; if (mem_we_o !== 1'b1 || mem_adr_o !== 32'h2000 || mem_be_o !== 4'hF || mem_wdata_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL both_store_payload got we=%0b adr=%0h be=%0h d=%0h want 1/2000/f/deadbeef", mem_we_o, mem_adr_o, mem_be_o, mem_wdata_o); end
    tick; ls_req_v_i = 1'b0; ls_we_i = 1'b0;
    tick; mem_rsp_v_i = 1'b1; mem_rdata_i = 32'h0;
    @(negedge clk);
    checks++; if (ls_rsp_v_o !== 1'b1 || if_rsp_v_o !== 1'b0) begin errors++; $display("FAIL both_store_ack got ls=%0b if=%0b want 1/0", ls_rsp_v_o, if_rsp_v_o); end
    tick; mem_rsp_v_i = 1'b0;
    @(negedge clk);
    checks++; if (if_gnt_o !== 1'b1 || mem_adr_o !== 32'h200 || mem_we_o !== 1'b0) begin errors++; $display("FAIL both_if_next got gnt=%0b adr=%0h we=%0b want 1/200/0", if_gnt_o, mem_adr_o, mem_we_o); end
    tick; if_req_v_i = 1'b0;
    tick; mem_rsp_v_i = 1'b1;
    tick; mem_rsp_v_i = 1'b0;
  endtask

  task automatic test_starvation;
    if_req_v_i = 1'b1; if_adr_i = 32'h0000_0300;
    ls_req_v_i = 1'b1; ls_adr_i = 32'h0000_3000;
    for (int k = 1; k <= SMAX + 1; k++) begin
      @(negedge clk);
      checks++;
      if (if_gnt_o !== (k > SMAX) || ls_gnt_o !== (k <= SMAX)) begin
        errors++; $display("FAIL starve_arb%0d got if=%0b ls=%0b want if=%0b", k, if_gnt_o, ls_gnt_o, k > SMAX);
      end
      tick; if (k > SMAX) if_req_v_i = 1'b0;
      mem_rsp_v_i = 1'b1;
      tick; mem_rsp_v_i = 1'b0;
    end
    ls_req_v_i = 1'b0;
    @(negedge clk);
    checks++; if (dut.starve_q !== 3'd0) begin errors++; $display("FAIL starve_clear got %0d want 0", dut.starve_q); end
    tick;
  endtask

  task automatic test_flush;
    if_req_v_i = 1'b1; if_adr_i = 32'h0000_0400;
    @(negedge clk);
    checks++; if (if_gnt_o !== 1'b1) begin errors++; $display("FAIL flush_gnt got %0b want 1", if_gnt_o); end
    tick; if_req_v_i = 1'b0; flush_v_i = 1'b1;
    tick; flush_v_i = 1'b0; mem_rsp_v_i = 1'b1; mem_rdata_i = 32'h0000_0055;
    @(negedge clk);
    checks++; if (if_rsp_v_o !== 1'b0) begin errors++; $display("FAIL flush_kill got %0b want 0", if_rsp_v_o); end
    tick; mem_rsp_v_i = 1'b0;
    @(negedge clk);
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL flush_idle got %0d want 0", dut.state_q); end
  endtask

  task automatic test_reset_mid;
    ls_req_v_i = 1'b1; ls_adr_i = 32'h0000_0500; ls_we_i = 1'b0;
    @(negedge clk);
    checks++; if (ls_gnt_o !== 1'b1) begin errors++; $display("FAIL rmid_gnt got %0b want 1", ls_gnt_o); end
    tick; ls_req_v_i = 1'b0; reset_n = 1'b0;
    @(negedge clk);
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL rmid_state got %0d want 0", dut.state_q); end
    tick; reset_n = 1'b1;
    tick;
    tick; mem_rsp_v_i = 1'b1; mem_rdata_i = 32'h0000_0077;
    @(negedge clk);
    checks++; if (ls_rsp_v_o !== 1'b0 || if_rsp_v_o !== 1'b0 || dut.state_q !== IDLE) begin errors++; $display("FAIL rmid_late got ls=%0b if=%0b st=%0d want 0/0/0", ls_rsp_v_o, if_rsp_v_o, dut.state_q); end
    tick; mem_rsp_v_i = 1'b0; if_req_v_i = 1'b1; if_adr_i = 32'h0000_0600;
    @(negedge clk);
    checks++; if (if_gnt_o !== 1'b1 || mem_adr_o !== 32'h600) begin errors++; $display("FAIL rmid_new got gnt=%0b adr=%0h want 1/600", if_gnt_o, mem_adr_o); end
    tick; if_req_v_i = 1'b0;
    tick; mem_rsp_v_i = 1'b1; mem_rdata_i = 32'h0000_0600;
    @(negedge clk);
    checks++; if (if_rsp_v_o !== 1'b1) begin errors++; $display("FAIL rmid_rsp got %0b want 1", if_rsp_v_o); end
    tick; mem_rsp_v_i = 1'b0;
  endtask

  task automatic test_rdy_stall;
    mem_rdy_i = 1'b0; if_req_v_i = 1'b1; if_adr_i = 32'h0000_0700;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (mem_req_v_o !== 1'b1 || mem_adr_o !== 32'h700 || if_gnt_o !== 1'b0) begin
        errors++; $display("FAIL stall%0d got req=%0b adr=%0h gnt=%0b want 1/700/0", i, mem_req_v_o, mem_adr_o, if_gnt_o);
      end
      tick;
    end
    mem_rdy_i = 1'b1;
    @(negedge clk);
    checks++; if (if_gnt_o !== 1'b1) begin errors++; $display("FAIL stall_release got %0b want 1", if_gnt_o); end
    tick; if_req_v_i = 1'b0;
    tick; mem_rsp_v_i = 1'b1;
    tick; mem_rsp_v_i = 1'b0;
  endtask

  task automatic test_random;
    bit   busy, own_if, kill, e_issue, e_ifw, e_ifg, e_lsg;
    int   losses, lat;
    logic [31:0] e_adr;
    busy = 1'b0; own_if = 1'b0; kill = 1'b0; losses = 0; lat = 0;
    e_ifg = 1'b0; e_lsg = 1'b0;
    idle_inputs; reset_n = 1'b0;
    tick; tick; reset_n = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      tick;
      if (!if_req_v_i || e_ifg) begin
        if_req_v_i = ($urandom_range(0, 2) != 0); if_adr_i = $urandom;
      end
      if (!ls_req_v_i || e_lsg) begin
        ls_req_v_i = ($urandom_range(0, 2) != 0); ls_adr_i = $urandom; ls_we_i = 1'($urandom);
        ls_be_i = 4'($urandom); ls_wdata_i = $urandom;
      end
      mem_rdy_i = ($urandom_range(0, 3) != 0);
      flush_v_i = ($urandom_range(0, 7) == 0);
      if (busy) begin
        mem_rsp_v_i = (lat == 0);
        if (lat > 0) lat--;
      end else begin
        mem_rsp_v_i = ($urandom_range(0, 7) == 0);
      end
      mem_rdata_i = $urandom;
      @(negedge clk);
      // Fetch wins only when alone or after SMAX consecutive losses.
      e_issue = !busy && (if_req_v_i || ls_req_v_i);
      e_ifw   = if_req_v_i && (!ls_req_v_i || losses >= SMAX);
      e_ifg   = e_issue && e_ifw && mem_rdy_i;
      e_lsg   = e_issue && !e_ifw && mem_rdy_i;
      e_adr   = !e_issue ? 32'h0 : (e_ifw ? if_adr_i : ls_adr_i);
      checks++; if (mem_req_v_o !== e_issue) begin errors++; $display("FAIL rnd_req c%0d got %0b want %0b", c, mem_req_v_o, e_issue); end
      checks++; if (if_gnt_o !== e_ifg || ls_gnt_o !== e_lsg) begin errors++; $display("FAIL rnd_gnt c%0d got if=%0b ls=%0b want if=%0b ls=%0b", c, if_gnt_o, ls_gnt_o, e_ifg, e_lsg); end
      checks++; if (mem_adr_o !== e_adr) begin errors++; $display("FAIL rnd_adr c%0d got %0h want %0h", c, mem_adr_o, e_adr); end
      if (e_issue && !e_ifw) begin
        checks++;
        if (mem_we_o !== ls_we_i || mem_be_o !== ls_be_i || mem_wdata_o !== ls_wdata_i) begin
          errors++; $display("FAIL rnd_lspay c%0d got we=%0b be=%0h d=%0h want %0b/%0h/%0h", c, mem_we_o, mem_be_o, mem_wdata_o, ls_we_i, ls_be_i, ls_wdata_i);
        end
      end
      checks++;
      if (if_rsp_v_o !== (busy && own_if && mem_rsp_v_i && !kill && !flush_v_i) || ls_rsp_v_o !== (busy && !own_if && mem_rsp_v_i)) begin
        errors++; $display("FAIL rnd_rsp c%0d got if=%0b ls=%0b busy=%0b own_if=%0b kill=%0b", c, if_rsp_v_o, ls_rsp_v_o, busy, own_if, kill);
      end
      checks++; if (if_rsp_data_o !== mem_rdata_i || ls_rsp_data_o !== mem_rdata_i) begin errors++; $display("FAIL rnd_rdata c%0d got %0h/%0h want %0h", c, if_rsp_data_o, ls_rsp_data_o, mem_rdata_i); end
      if (busy) begin
        if (mem_rsp_v_i) begin busy = 1'b0; kill = 1'b0; end
        else if (own_if && flush_v_i) kill = 1'b1;
      end else begin
        if (e_ifg) begin
          busy = 1'b1; own_if = 1'b1; kill = flush_v_i; losses = 0; lat = $urandom_range(0, 2);
        end else if (e_lsg) begin
          busy = 1'b1; own_if = 1'b0; kill = 1'b0; lat = $urandom_range(0, 2);
          if (if_req_v_i) losses = (losses < SMAX) ? losses + 1 : SMAX;
        end
        if (!if_req_v_i) losses = 0;
      end
    end
    idle_inputs;
  endtask

  initial begin
    idle_inputs;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    test_if_only;
    tick; test_both_store;
    tick; test_starvation;
    tick; test_flush;
    tick; test_reset_mid;
    tick; test_rdy_stall;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4, meaning consecutive fetch losses before fetch is forced to win.
REQ-002 SHALL have port clk  in  1  single clock, all flops on rising edge.
REQ-003 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have fetch ports: if_req_v_i in 1 request; if_adr_i in XLEN address; if_gnt_o out 1 request accepted; if_rsp_v_o out 1 instruction valid; if_rsp_data_o out 32 instruction.
REQ-005 SHALL have load/store ports: ls_req_v_i in 1; ls_adr_i in XLEN; ls_we_i in 1 write; ls_be_i in 4 byte enables; ls_wdata_i in 32; ls_gnt_o out 1; ls_rsp_v_o out 1; ls_rsp_data_o out 32.
REQ-006 SHALL have flush_v_i in 1, an EXE redirect that kills the pending fetch.
REQ-007 SHALL have memory ports: mem_req_v_o out 1; mem_adr_o out XLEN; mem_we_o out 1; mem_be_o out 4; mem_wdata_o out 32; mem_rdy_i in 1; mem_rsp_v_i in 1; mem_rdata_i in 32.

Function
REQ-008 SHALL use FSM states IDLE, WAIT_IF, WAIT_LS, with exactly one memory transaction outstanding.
REQ-009 SHALL issue requests only in IDLE: mem_req_v_o = IDLE & (if_req_v_i | ls_req_v_i); address/we/be/wdata come combinationally from the selected requester.
REQ-010 SHALL select as follows: LS wins when both request, unless starve_q == STARVE_MAX, in which case IF wins.
REQ-011 SHALL assert the grant of the selected requester only when mem_req_v_o & mem_rdy_i; the unselected grant stays 0.
REQ-012 SHALL require requesters to hold valid and payload stable until granted; the arbiter does not latch payload.
REQ-013 SHALL move IDLE->WAIT_IF on an IF grant and IDLE->WAIT_LS on an LS grant, and stay in IDLE otherwise.
REQ-014 SHALL move WAIT_x->IDLE on mem_rsp_v_i, with no issue in that cycle; minimum occupancy is therefore 2 cycles per transaction.
REQ-015 SHALL set if_rsp_v_o = WAIT_IF & mem_rsp_v_i & ~drop_q & ~flush_v_i and ls_rsp_v_o = WAIT_LS & mem_rsp_v_i; both response data outputs equal mem_rdata_i, same cycle, and writes also pulse ls_rsp_v_o.
REQ-016 SHALL set drop_q on flush_v_i while in WAIT_IF, or in the cycle an IF grant occurs, and clear it on the transition to IDLE.
REQ-017 SHALL hold starve_q at 3 bits saturating at STARVE_MAX: +1 on each LS grant while if_req_v_i=1; cleared on an IF grant or whenever if_req_v_i=0 in IDLE.
REQ-018 SHALL ignore mem_rsp_v_i in IDLE, with no output pulse and no state change.
REQ-019 SHALL ignore flush_v_i during WAIT_LS, so loads and stores always complete.

Reset
REQ-020 SHALL, while reset_n=0, hold state=IDLE, drop_q=0, starve_q=0, and all outputs 0; mem_adr_o and mem_wdata_o are 0 because no requester is selected.
REQ-021 SHALL discard any outstanding transaction on reset mid-operation; a late mem_rsp_v_i after reset is ignored per REQ-018.
REQ-022 SHALL accept a request in the first cycle after reset_n rises.

Structure
REQ-023 SHALL declare the enum arb_state_t {IDLE, WAIT_IF, WAIT_LS} and the constant ARB_STARVE_MAX in riscv_pkg.
REQ-024 SHALL be a single flat module with no sub-modules; the counter and the FSM are small.

Verification
REQ-025 Only IF requests at 0x100, mem_rdy_i=1, response after 3 cycles with 0x00000013 -> if_gnt_o for 1 cycle, if_rsp_v_o for 1 cycle with 0x00000013, state back to IDLE.
REQ-026 IF and LS request together, LS store to 0x2000 with be=0xF and data 0xDEADBEEF -> LS granted first with mem_we_o=1, ls_rsp_v_o on ack; IF granted next.
REQ-027 LS requests every IDLE cycle while IF is held -> IF granted on its 5th arbitration, i.e. after 4 LS grants; starve_q then returns to 0.
REQ-028 flush_v_i pulses 1 cycle after an IF grant -> the memory response is consumed, if_rsp_v_o stays 0, and the FSM returns to IDLE.
REQ-029 reset_n is dropped during WAIT_LS and a response arrives 2 cycles after release -> no ls_rsp_v_o, FSM in IDLE, and a new IF request is granted normally.
REQ-030 mem_rdy_i=0 for 3 cycles with IF requesting -> mem_req_v_o stays 1 with a stable address and no grant; the grant comes in the cycle mem_rdy_i rises.
